// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tone_seq_pkg;

  // NCO step word: 8 integer + 24 fractional bits.
  localparam int ACC_WIDTH   = 32;
  // Dwell length in NCO output samples.
  localparam int DWELL_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    ABORT = 2'd3
  } state_t;

  // One hop segment at the default widths.
  typedef struct packed {
    logic [ACC_WIDTH-1:0]   step;
    logic [DWELL_WIDTH-1:0] dwell;
  } seg_t;

endpackage

// File: rtl/tone_seq_table.sv
// Segment table: N_SEG x {step, dwell} flops, one sync write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; writes are always accepted when we=1.
//
// Ports:
//   aclk, arst_n          clock and synchronous active-low reset (clears all entries to {0,0})
//   we/wr_addr/wr_step/wr_dwell   write port
//   rd_addr -> rd_step/rd_dwell   asynchronous read port
module tone_seq_table #(
  parameter int N_SEG       = 8,
  parameter int ACC_WIDTH   = tone_seq_pkg::ACC_WIDTH,
  parameter int DWELL_WIDTH = tone_seq_pkg::DWELL_WIDTH,
  localparam int IDX_W      = $clog2(N_SEG)
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [ACC_WIDTH-1:0]   wr_step,
  input  logic [DWELL_WIDTH-1:0] wr_dwell,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [ACC_WIDTH-1:0]   rd_step,
  output logic [DWELL_WIDTH-1:0] rd_dwell
);

  // Same layout as tone_seq_pkg::seg_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ACC_WIDTH-1:0]   step;
    logic [DWELL_WIDTH-1:0] dwell;
  } entry_t;

  entry_t mem [N_SEG];

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      for (int i = 0; i < N_SEG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= '{step: wr_step, dwell: wr_dwell};
    end
  end

  assign rd_step  = mem[rd_addr].step;
  assign rd_dwell = mem[rd_addr].dwell;

endmodule

// File: rtl/axis_tone_sequencer.sv
// Frequency-hop scheduler: plays {step, dwell} segments to the NCO step port over AXI-Stream.
// Latency: start -> tvalid next cycle; last sample_en of a segment -> next step tvalid next cycle.
// Backpressure: step word (or abort zero word) held stable with tvalid=1 until tready; dwell starts after handshake.
//
// Ports:
//   aclk, arst_n                    clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_step/cfg_dwell   table write (IDLE only)
//   cfg_nseg, cfg_loop              segment count (clamped to N_SEG) and loop mode, sampled on start
//   start, stop                     begin playback / abort
//   sample_en                       NCO output tvalid, one pulse per sample
//   m_axis_step_*                   AXI-Stream step word to the NCO
//   busy, seg_idx, done             status
module axis_tone_sequencer #(
  parameter int ACC_WIDTH   = tone_seq_pkg::ACC_WIDTH,
  parameter int N_SEG       = 8,
  parameter int DWELL_WIDTH = tone_seq_pkg::DWELL_WIDTH,
  localparam int IDX_W      = $clog2(N_SEG)
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [ACC_WIDTH-1:0]   cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [IDX_W:0]         cfg_nseg,
  input  logic                   cfg_loop,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sample_en,
  output logic [ACC_WIDTH-1:0]   m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   busy,
  output logic [IDX_W-1:0]       seg_idx,
  output logic                   done
);

  import tone_seq_pkg::*;

  state_t                 state;
  logic [IDX_W:0]         nseg_q;
  logic                   loop_q;
  logic [DWELL_WIDTH-1:0] cnt;

  logic [IDX_W:0]         nseg_clamp;
  logic                   last_seg;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W-1:0]       rd_addr;
  logic [ACC_WIDTH-1:0]   rd_step;
  logic [DWELL_WIDTH-1:0] rd_dwell;
  logic [DWELL_WIDTH-1:0] dwell_ld;
  logic                   table_we;

  always_comb begin
    nseg_clamp = (cfg_nseg > (IDX_W+1)'(N_SEG)) ? (IDX_W+1)'(N_SEG) : cfg_nseg;
    // nseg_q is at least 1 whenever this is consulted (LOAD/DWELL only).
    last_seg   = ({1'b0, seg_idx} == (nseg_q - (IDX_W+1)'(1)));
    next_idx   = last_seg ? '0 : (seg_idx + IDX_W'(1));
    // Single read port: IDLE pre-reads entry 0 for the start edge, DWELL
    // pre-reads the following entry so the next step word is ready on the
    // final sample, LOAD/ABORT read the current entry for its dwell.
    case (state)
      IDLE:    rd_addr = '0;
      DWELL:   rd_addr = next_idx;
      default: rd_addr = seg_idx;
    endcase
    // A zero dwell still holds the segment for one sample.
    dwell_ld   = (rd_dwell == '0) ? DWELL_WIDTH'(1) : rd_dwell;
    table_we   = cfg_we && (state == IDLE);
  end

  tone_seq_table #(
    .N_SEG       (N_SEG),
    .ACC_WIDTH   (ACC_WIDTH),
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_table (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .we       (table_we),
    .wr_addr  (cfg_addr),
    .wr_step  (cfg_step),
    .wr_dwell (cfg_dwell),
    .rd_addr  (rd_addr),
    .rd_step  (rd_step),
    .rd_dwell (rd_dwell)
  );

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state              <= IDLE;
      nseg_q             <= '0;
      loop_q             <= 1'b0;
      cnt                <= '0;
      m_axis_step_tdata  <= '0;
      m_axis_step_tvalid <= 1'b0;
      busy               <= 1'b0;
      seg_idx            <= '0;
      done               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            nseg_q <= nseg_clamp;
            loop_q <= cfg_loop;
            if (nseg_clamp == '0) begin
              done <= 1'b1;
            end else begin
              seg_idx            <= '0;
              m_axis_step_tdata  <= rd_step;
              m_axis_step_tvalid <= 1'b1;
              busy               <= 1'b1;
              state              <= LOAD;
            end
          end
        end

        LOAD: begin
          // A handshake coinciding with stop still counts; abort follows.
          if (stop) begin
            m_axis_step_tdata  <= '0;
            m_axis_step_tvalid <= 1'b1;
            state              <= ABORT;
          end else if (m_axis_step_tready) begin
            m_axis_step_tvalid <= 1'b0;
            cnt                <= dwell_ld;
            state              <= DWELL;
          end
        end

        DWELL: begin
          if (stop) begin
            m_axis_step_tdata  <= '0;
            m_axis_step_tvalid <= 1'b1;
            state              <= ABORT;
          end else if (sample_en) begin
            cnt <= cnt - DWELL_WIDTH'(1);
            if (cnt == DWELL_WIDTH'(1)) begin
              if (!last_seg || loop_q) begin
                seg_idx            <= next_idx;
                m_axis_step_tdata  <= rd_step;
                m_axis_step_tvalid <= 1'b1;
                state              <= LOAD;
              end else begin
                // One-shot end: the NCO keeps the last step word.
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end

        ABORT: begin
          // Zero step freezes the NCO phase; stop is ignored here.
          if (m_axis_step_tready) begin
            m_axis_step_tvalid <= 1'b0;
            done               <= 1'b1;
            busy               <= 1'b0;
            state              <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_tone_sequencer.md
Name: axis_tone_sequencer

Overview:
- Programmable frequency-hop scheduler that sequences the phase-increment (step) input of the NCO feeding the MASH 1-1 / second-order DSM DAC chain.
- Holds a small table of {step, dwell} segments and plays them in order. Each step word goes out over AXI-Stream to the NCO's step slave port.
- Each segment is held for DWELL NCO output samples, counted on the NCO's m_axis tvalid.
- Supports one-shot or looped playback, abort, and status reporting.

Parameters:
- ACC_WIDTH, 32, NCO step/accumulator width (8 integer + 24 fractional bits).
- N_SEG, 8, number of table entries (power of 2, at least 2).
- DWELL_WIDTH, 24, dwell counter width, in samples.

Ports:
- aclk  in  1  clock.
- arst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(N_SEG)  table write index.
- cfg_step  in  ACC_WIDTH  step word to write.
- cfg_dwell  in  DWELL_WIDTH  dwell to write, in samples.
- cfg_nseg  in  $clog2(N_SEG)+1  number of active segments, 0..N_SEG.
- cfg_loop  in  1  wrap to segment 0 after the last segment.
- start  in  1  begin playback (level sampled in IDLE).
- stop  in  1  abort playback.
- sample_en  in  1  NCO output tvalid, one pulse per sample.
- m_axis_step_tdata  out  ACC_WIDTH  step word to the NCO.
- m_axis_step_tvalid  out  1  step word valid.
- m_axis_step_tready  in  1  NCO ready.
- busy  out  1  high in any state other than IDLE.
- seg_idx  out  $clog2(N_SEG)  index of the current segment.
- done  out  1  one-cycle pulse at the end of playback or abort.

Behaviour:
- Reset, synchronous on the aclk edge with arst_n=0:
  - state=IDLE, all table entries = {0,0}.
  - tdata=0, tvalid=0, busy=0, seg_idx=0, done=0, dwell counter=0.
  - Reset takes effect mid-handshake: tvalid drops without waiting for tready.
- Table:
  - Flop array with asynchronous read.
  - Writes accepted only in IDLE; cfg_we is ignored while busy.
  - cfg_nseg, cfg_loop and cfg_nseg>N_SEG (clamped to N_SEG) are sampled on the start edge.
- States:
  - IDLE: on start=1 and stop=0:
    - If nseg=0: pulse done next cycle and stay in IDLE.
    - Otherwise: seg_idx←0 and go to LOAD.
  - LOAD:
    - tdata=table[seg_idx].step, tvalid=1.
    - tdata is held stable until tready.
    - On handshake: cnt←max(dwell,1) and go to DWELL.
    - sample_en is ignored in LOAD.
  - DWELL:
    - tvalid=0; tdata holds its last value.
    - Each sample_en decrements cnt.
    - On the sample_en that brings cnt 1→0:
      - If seg_idx<nseg-1: seg_idx+1, go to LOAD.
      - Else if loop: seg_idx←0, go to LOAD.
      - Else: done pulse, go to IDLE.
  - ABORT:
    - stop=1 in LOAD or DWELL moves to ABORT next cycle.
    - ABORT emits tdata=0 with tvalid=1 (freezes NCO phase) and waits for tready.
    - Then done pulse, go to IDLE.
- Latency:
  - start sampled at cycle 0 → tvalid=1 at cycle 1.
  - Final sample_en of a segment at cycle k → next segment's tvalid at cycle k+1.
- Simultaneous events:
  - start and stop in IDLE: nothing happens.
  - stop during a LOAD handshake cycle: the handshake completes, then ABORT.
  - stop in ABORT: ignored.
- At one-shot end the NCO keeps the last step; this block does not drive 0.
- done is high only in the cycle after the IDLE transition.

Decomposition:
- Package tone_seq_pkg:
  - state_t enum {IDLE, LOAD, DWELL, ABORT}.
  - Default width localparams (ACC_WIDTH, DWELL_WIDTH).
  - seg_t struct {step, dwell}.
- Sub-module tone_seq_table: N_SEG×seg_t register file, one synchronous write port, one asynchronous read port, synchronous reset.
- FSM, dwell counter and AXIS output register live in axis_tone_sequencer.

Test Plan:
- One-shot hop:
  - Stimulus: table {1<<22, dwell 4}, {85900, dwell 2}; nseg=2, loop=0; tready=1; sample_en every cycle.
  - Response: tdata 4194304 handshakes at cycle 1, 85900 at cycle 6, done at cycle 9, busy low afterwards.
- Backpressure:
  - Stimulus: tready=0 for 5 cycles during LOAD.
  - Response: tvalid stays 1, tdata is stable, dwell does not start until the handshake, sample_en pulses during the stall are ignored.
- Loop wrap:
  - Stimulus: nseg=3, loop=1, dwell=1 each.
  - Response: seg_idx sequence 0,1,2,0,1 and no done.
  - Then stop in DWELL → tdata=0 handshake, then done, then IDLE.
- Edge values:
  - nseg=0 → done one cycle after start, tvalid never asserted.
  - dwell=0 → treated as 1 sample.
  - cfg_we while busy → table unchanged (read back after return to IDLE).
- Sparse samples:
  - Stimulus: sample_en every 4th cycle, dwell=3.
  - Response: segment ends on the 3rd pulse; next tvalid asserted exactly 1 cycle later.
- Reset mid-run:
  - Stimulus: arst_n=0 for one cycle during DWELL.
  - Response: all outputs return to reset values on that edge; the table is cleared to {0,0}.
